// File: rtl/haze_pkg.sv
// Shared definitions for the dark-channel haze-removal pipeline.
package haze_pkg;

   localparam int unsigned PIX_W          = 8;
   localparam int unsigned DEF_IMG_WIDTH  = 640;
   localparam int unsigned DEF_IMG_HEIGHT = 480;

   typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store: asynchronous read of the current contents and a synchronous
// write to the same address, giving read-before-write behaviour. Contents are not reset.
module line_buffer #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   // Write the new value at the end of the cycle; the read above still sees the old one.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Emits only full interior windows, one cycle
// after the pixel that completes each window is accepted.
module window3x3_gen #(
   parameter int unsigned IMG_WIDTH  = haze_pkg::DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = haze_pkg::DEF_IMG_HEIGHT,
   parameter int unsigned PIX_W      = haze_pkg::PIX_W
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [PIX_W-1:0]              pixel_in,
   input  logic                          pixel_in_valid,
   output logic [PIX_W-1:0]              pixel_1,
   output logic [PIX_W-1:0]              pixel_2,
   output logic [PIX_W-1:0]              pixel_3,
   output logic [PIX_W-1:0]              pixel_4,
   output logic [PIX_W-1:0]              pixel_5,
   output logic [PIX_W-1:0]              pixel_6,
   output logic [PIX_W-1:0]              pixel_7,
   output logic [PIX_W-1:0]              pixel_8,
   output logic [PIX_W-1:0]              pixel_9,
   output logic                          window_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0] center_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  center_col,
   output logic                          frame_done
);

   import haze_pkg::*;

   localparam int unsigned COL_W = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0] col_q, prev_col_q, ccol_q;
   logic [ROW_W-1:0] row_q, prev_row_q, crow_q;
   logic             valid_q, done_q;
   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] top, mid;
   logic             accept;

   // Reset wins over a simultaneous pixel, which is then dropped.
   assign accept = pixel_in_valid && !reset;

   line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
   ) u_lb0 (
      .clock   (clock),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (pixel_in),
      .rd_data (mid)
   );

   line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W)
   ) u_lb1 (
      .clock   (clock),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (mid),
      .rd_data (top)
   );

   // Raster counters; prev_* remember the previous column/row so the window centre
   // (r-1, c-1) comes out without any subtraction.
   always_ff @(posedge clock) begin
      if (reset) begin
         col_q      <= '0;
         row_q      <= '0;
         prev_col_q <= '0;
         prev_row_q <= '0;
      end else if (pixel_in_valid) begin
         prev_col_q <= col_q;
         if (col_q == COL_LAST) begin
            col_q      <= '0;
            prev_row_q <= row_q;
            row_q      <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // 3x3 register array: each row shifts left, new right column from buffers and input.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else if (pixel_in_valid) begin
         for (int i = 0; i < 3; i++) begin
            win_q[3*i]   <= win_q[3*i+1];
            win_q[3*i+1] <= win_q[3*i+2];
         end
         win_q[2] <= top;
         win_q[5] <= mid;
         win_q[8] <= pixel_in;
      end
   end

   // Window/frame flags are single-cycle pulses; centre coordinates hold between windows.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         crow_q  <= '0;
         ccol_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         if (pixel_in_valid) begin
            if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
               valid_q <= 1'b1;
               crow_q  <= prev_row_q;
               ccol_q  <= prev_col_q;
            end
            done_q <= (row_q == ROW_LAST) && (col_q == COL_LAST);
         end
      end
   end

   assign pixel_1      = win_q[0];
   assign pixel_2      = win_q[1];
   assign pixel_3      = win_q[2];
   assign pixel_4      = win_q[3];
   assign pixel_5      = win_q[4];
   assign pixel_6      = win_q[5];
   assign pixel_7      = win_q[6];
   assign pixel_8      = win_q[7];
   assign pixel_9      = win_q[8];
   assign window_valid = valid_q;
   assign frame_done   = done_q;
   assign center_row   = crow_q;
   assign center_col   = ccol_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench: a 5x4 instance for the main scenarios and a 3x3 instance for the
// minimum geometry. Expected windows are queued at stimulus time, popped by monitors.
module tb_window3x3_gen;

   typedef struct {
      logic [71:0] pix;
      int          row;
      int          col;
      bit          fd;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- 5x4 instance ----------------
   logic       reset = 1'b1;
   logic [7:0] pixel_in = '0;
   logic       pixel_in_valid = 1'b0;
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic       window_valid, frame_done;
   logic [1:0] center_row;
   logic [2:0] center_col;

   window3x3_gen #(
      .IMG_WIDTH  (5),
      .IMG_HEIGHT (4),
      .PIX_W      (8)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pixel_in       (pixel_in),
      .pixel_in_valid (pixel_in_valid),
      .pixel_1        (p1),
      .pixel_2        (p2),
      .pixel_3        (p3),
      .pixel_4        (p4),
      .pixel_5        (p5),
      .pixel_6        (p6),
      .pixel_7        (p7),
      .pixel_8        (p8),
      .pixel_9        (p9),
      .window_valid   (window_valid),
      .center_row     (center_row),
      .center_col     (center_col),
      .frame_done     (frame_done)
   );

   // ---------------- 3x3 instance ----------------
   logic       s_reset = 1'b1;
   logic [7:0] s_pixel_in = '0;
   logic       s_valid = 1'b0;
   logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
   logic       s_window_valid, s_frame_done;
   logic [1:0] s_center_row;
   logic [1:0] s_center_col;

   window3x3_gen #(
      .IMG_WIDTH  (3),
      .IMG_HEIGHT (3),
      .PIX_W      (8)
   ) dut_s (
      .clock          (clock),
      .reset          (s_reset),
      .pixel_in       (s_pixel_in),
      .pixel_in_valid (s_valid),
      .pixel_1        (s1),
      .pixel_2        (s2),
      .pixel_3        (s3),
      .pixel_4        (s4),
      .pixel_5        (s5),
      .pixel_6        (s6),
      .pixel_7        (s7),
      .pixel_8        (s8),
      .pixel_9        (s9),
      .window_valid   (s_window_valid),
      .center_row     (s_center_row),
      .center_col     (s_center_col),
      .frame_done     (s_frame_done)
   );

   exp_t q_a[$];
   exp_t q_s[$];
   int   win_cnt = 0;
   int   s_win_cnt = 0;
   bit   acc_last = 1'b0;
   bit   s_acc_last = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Window with bottom-right pixel at (r,c) of a frame whose pixels are base + row*16 + col.
   function automatic exp_t make_exp(input int base, input int r, input int c, input int w,
                                     input int h);
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            e.pix[71-8*(3*i+j) -: 8] = 8'(base + (r - 2 + i) * 16 + (c - 2 + j));
         end
      end
      e.row = r - 1;
      e.col = c - 1;
      e.fd  = (r == h - 1) && (c == w - 1);
      return e;
   endfunction

   always @(posedge clock) begin
      acc_last   <= pixel_in_valid && !reset;
      s_acc_last <= s_valid && !s_reset;
   end

   // Monitor for the 5x4 instance.
   always @(negedge clock) begin
      if (window_valid) begin
         exp_t e;
         win_cnt++;
         check("valid_only_after_accept", 128'(acc_last), 128'(1));
         if (q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_window: got window %0h with no expected entry",
                     {p1, p2, p3, p4, p5, p6, p7, p8, p9});
         end else begin
            e = q_a.pop_front();
            check("window_pixels", 128'({p1, p2, p3, p4, p5, p6, p7, p8, p9}), 128'(e.pix));
            check("center_row", 128'(center_row), 128'(e.row));
            check("center_col", 128'(center_col), 128'(e.col));
            check("frame_done", 128'(frame_done), 128'(e.fd));
         end
      end else if (frame_done) begin
         check("frame_done_without_window", 128'(frame_done), 128'(0));
      end
   end

   // Monitor for the 3x3 instance.
   always @(negedge clock) begin
      if (s_window_valid) begin
         exp_t e;
         s_win_cnt++;
         check("s_valid_only_after_accept", 128'(s_acc_last), 128'(1));
         if (q_s.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_unexpected_window: got window %0h with no expected entry",
                     {s1, s2, s3, s4, s5, s6, s7, s8, s9});
         end else begin
            e = q_s.pop_front();
            check("s_window_pixels", 128'({s1, s2, s3, s4, s5, s6, s7, s8, s9}), 128'(e.pix));
            check("s_center_row", 128'(s_center_row), 128'(e.row));
            check("s_center_col", 128'(s_center_col), 128'(e.col));
            check("s_frame_done", 128'(s_frame_done), 128'(e.fd));
         end
      end else if (s_frame_done) begin
         check("s_frame_done_without_window", 128'(s_frame_done), 128'(0));
      end
   end

   int m_row = 0;
   int m_col = 0;

   // Sends one pixel to the 5x4 instance, optionally preceded by a random idle gap.
   task automatic send(input int base, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 1)) begin
            pixel_in_valid = 1'b0;
            @(posedge clock);
            #1;
         end
      end
      pixel_in       = 8'(base + m_row * 16 + m_col);
      pixel_in_valid = 1'b1;
      if (m_row >= 2 && m_col >= 2) q_a.push_back(make_exp(base, m_row, m_col, 5, 4));
      @(posedge clock);
      #1;
      pixel_in_valid = 1'b0;
      if (m_col == 4) begin
         m_col = 0;
         m_row = (m_row == 3) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic run_frame(input int base, input bit gaps, input int npix);
      for (int k = 0; k < npix; k++) send(base, gaps);
   endtask

   task automatic idle(input int n);
      pixel_in_valid = 1'b0;
      s_valid        = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   int c0;

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs",
            128'({p1, p2, p3, p4, p5, p6, p7, p8, p9, window_valid, frame_done,
                  center_row, center_col}), 128'(0));
      check("s_reset_outputs",
            128'({s1, s2, s3, s4, s5, s6, s7, s8, s9, s_window_valid, s_frame_done,
                  s_center_row, s_center_col}), 128'(0));
      reset   = 1'b0;
      s_reset = 1'b0;

      // Continuous frame followed back-to-back by a frame offset by 0x80.
      c0 = win_cnt;
      run_frame(0, 1'b0, 20);
      run_frame(8'h80, 1'b0, 20);
      idle(3);
      check("windows_two_frames", 128'(win_cnt - c0), 128'(12));

      // Same frame with random idle gaps.
      c0 = win_cnt;
      run_frame(0, 1'b1, 20);
      idle(3);
      check("windows_gapped_frame", 128'(win_cnt - c0), 128'(6));

      // Partial frame up to pixel 0x23, then reset together with a pixel that must drop.
      run_frame(0, 1'b0, 14);
      reset          = 1'b1;
      pixel_in       = 8'h24;
      pixel_in_valid = 1'b1;
      @(posedge clock);
      #1;
      check("mid_reset_outputs",
            128'({p1, p2, p3, p4, p5, p6, p7, p8, p9, window_valid, frame_done,
                  center_row, center_col}), 128'(0));
      reset          = 1'b0;
      pixel_in_valid = 1'b0;
      m_row          = 0;
      m_col          = 0;
      c0             = win_cnt;
      run_frame(0, 1'b0, 20);
      idle(3);
      check("windows_after_reset", 128'(win_cnt - c0), 128'(6));

      // Minimum geometry on the 3x3 instance.
      c0 = s_win_cnt;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            s_pixel_in = 8'(r * 16 + c);
            s_valid    = 1'b1;
            if (r == 2 && c == 2) q_s.push_back(make_exp(0, r, c, 3, 3));
            @(posedge clock);
            #1;
         end
      end
      idle(3);
      check("s_windows_one_frame", 128'(s_win_cnt - c0), 128'(1));

      check("queue_drained", 128'(q_a.size()), 128'(0));
      check("s_queue_drained", 128'(q_s.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3×3 neighbourhood generator feeding the 9-input minimum stage of the dark-channel path. It accepts one 8-bit pixel per valid cycle in raster order. Two internal line buffers plus a 3×3 register array present all nine window pixels in parallel, with a single-cycle `window_valid` that drives the minimum stage's `Enable`. Only full interior windows are produced; no border padding.

## Interface
Parameters:
- `IMG_WIDTH`, default 640: pixels per line, ≥3.
- `IMG_HEIGHT`, default 480: lines per frame, ≥3.
- `PIX_W`, default 8: pixel width.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pixel_in`  in  PIX_W  raster-order pixel.
- `pixel_in_valid`  in  1  `pixel_in` is accepted this cycle. No backpressure.
- `pixel_1`..`pixel_9`  out  PIX_W each  window in row-major order. `pixel_1` is top-left, `pixel_5` is centre, `pixel_9` is bottom-right (newest).
- `window_valid`  out  1  nine outputs form a valid window this cycle.
- `center_row`  out  clog2(IMG_HEIGHT)  row of `pixel_5`.
- `center_col`  out  clog2(IMG_WIDTH)  column of `pixel_5`.
- `frame_done`  out  1  one-cycle pulse after the frame's last pixel.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on accepted pixels.
  - `col` wraps to 0 at the end of a line and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next accepted pixel starts a new frame.
- Line buffers:
  - LB0 holds the previous line; LB1 holds the line before that.
  - Each is IMG_WIDTH × PIX_W, addressed by `col`, and uses read-before-write in the same cycle.
  - On an accepted pixel: read LB1[col] = top and LB0[col] = mid; write LB1[col] ← mid and LB0[col] ← `pixel_in`.
- Window array: on an accepted pixel, each row of the 3×3 array shifts left by one.
  - New right column: top → `pixel_3`, mid → `pixel_6`, `pixel_in` → `pixel_9`.
- Valid rule: the accepted pixel at (r,c) produces a window iff r≥2 and c≥2. Its centre is (r-1,c-1).
- Windows per frame: exactly (IMG_WIDTH-2)×(IMG_HEIGHT-2). No window straddles a line end or a frame boundary.
- Idle cycles (`pixel_in_valid`=0): counters, buffers and window array hold. `window_valid` = 0.
- No arithmetic beyond counter increment and compare. Coordinate outputs are unsigned and zero-extended.

## Timing
- Latency: 1 cycle. A pixel accepted at edge t produces its window and `window_valid` on the outputs after edge t+1.
- `window_valid` is high for exactly one cycle per window, and never on consecutive cycles unless pixels are accepted on consecutive cycles.
- `frame_done` asserts in the same cycle as the frame's final `window_valid`.
- Reset values:
  - `pixel_1`..`pixel_9` = 0.
  - `window_valid` = 0, `frame_done` = 0.
  - `center_row` = 0, `center_col` = 0.
  - `row` = 0, `col` = 0.
- Line-buffer contents are not reset. Stale data is never exposed because validity is gated by `row`≥2.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No window is emitted until the new frame reaches row 2, column 2.
- `reset` and `pixel_in_valid` high together: reset wins and the pixel is dropped.

## Structure
- Shared package `haze_pkg`:
  - `PIX_W`.
  - Default `IMG_WIDTH` and `IMG_HEIGHT`.
  - `pixel_t` typedef.
  - Shared by the minimum stage and downstream stages.
- Sub-module `line_buffer`:
  - Parameterised depth and width.
  - Synchronous write, read-before-write, no reset.
  - Instantiated twice.
- Top level: counters, window register array, valid/frame logic.

## Test plan
All scenarios except the last use IMG_WIDTH=5, IMG_HEIGHT=4, `pixel_in` = row·16 + col.
- Continuous frame:
  - First `window_valid` comes one cycle after pixel 0x22 is accepted, with `pixel_1`..`pixel_9` = 00,01,02,10,11,12,20,21,22 and centre (1,1).
  - Exactly 6 windows occur. The last window has centre (2,3) and `pixel_9` = 0x34, with `frame_done` high in that cycle.
- Random `pixel_in_valid` gaps (~50% duty):
  - The sequence of windows is identical to the continuous case.
  - No `window_valid` appears during idle cycles.
- Line wrap:
  - No window is emitted for pixels 0x30/0x31.
  - The first window of row 3 shows `pixel_7`..`pixel_9` = 30,31,32.
- Back-to-back frames:
  - The second frame uses values +0x80.
  - Its first window is 80,81,82,90,91,92,A0,A1,A2, with no mixing of data from frame 1.
- Reset mid-frame:
  - Assert `reset` after pixel 0x23.
  - All outputs read 0 the cycle after reset.
  - A restarted frame produces 6 correct windows.
- Minimum geometry IMG_WIDTH=3, IMG_HEIGHT=3: exactly one window, with `frame_done` high in the same cycle.
